// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and constants for the mm:ss.cc stopwatch counter.
package stopwatch_bcd_counter_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned DISP_W     = DIGIT_W * NUM_DIGITS;

   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_RUN  = 2'd1;
   localparam logic [1:0] ENC_STOP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ENC_IDLE,
      ST_RUN  = ENC_RUN,
      ST_STOP = ENC_STOP
   } state_t;

   typedef logic [DIGIT_W-1:0] bcd_t;
   typedef logic [DISP_W-1:0]  disp_t;

   localparam bcd_t  LIM_ONES = 4'd9;
   localparam bcd_t  LIM_TENS = 4'd5;
   localparam disp_t MAX_TIME = 24'h595999;

   // Digit positions within the display word, least significant first.
   localparam int unsigned DIG_CS_O  = 0;
   localparam int unsigned DIG_CS_T  = 1;
   localparam int unsigned DIG_SEC_O = 2;
   localparam int unsigned DIG_SEC_T = 3;
   localparam int unsigned DIG_MIN_O = 4;
   localparam int unsigned DIG_MIN_T = 5;

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Button/tick inputs and display outputs of the stopwatch counter.
interface stopwatch_bcd_counter_if;
   import stopwatch_bcd_counter_pkg::*;

   logic  tick_10ms;
   logic  btn_start_stop;
   logic  btn_clear;
   logic  btn_lap;
   disp_t digits;
   logic  running;
   logic  lap_active;
   logic  overflow;

   modport master (
      output tick_10ms, btn_start_stop, btn_clear, btn_lap,
      input  digits, running, lap_active, overflow
   );

   modport slave (
      input  tick_10ms, btn_start_stop, btn_clear, btn_lap,
      output digits, running, lap_active, overflow
   );

endinterface

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// One BCD digit of the cascade: counts 0..LIMIT on inc, carries out when wrapping.
module stopwatch_bcd_counter_bcd_digit
   import stopwatch_bcd_counter_pkg::*;
#(
   parameter bcd_t LIMIT = LIM_ONES
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output bcd_t q,
   output logic carry
);

   bcd_t q_nxt;

   always_comb begin
      q_nxt = q;
      if (clr) begin
         q_nxt = '0;
      end else if (inc) begin
         q_nxt = (q == LIMIT) ? '0 : q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= q_nxt;
      end
   end

   assign carry = inc & (q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: button edge detect, run/stop/clear FSM, lap freeze and the
// six-digit BCD mm:ss.cc counter driven by the 10 ms tick.
module stopwatch_bcd_counter
   import stopwatch_bcd_counter_pkg::*;
#(
   parameter bit WRAP_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   stopwatch_bcd_counter_if.slave sw
);

   logic   ss_q, clr_q, lap_q;
   logic   ss_rise, clr_rise, lap_rise;
   state_t state;
   logic   running_r, lap_active_r, overflow_r;
   disp_t  count, snapshot;
   logic   count_en, at_max, hold_stop, clr_count;
   logic [NUM_DIGITS-1:0] carry;

   // History keeps following the buttons during reset so a held button
   // does not produce a spurious edge when reset is released.
   always_ff @(posedge clk) begin
      ss_q  <= sw.btn_start_stop;
      clr_q <= sw.btn_clear;
      lap_q <= sw.btn_lap;
   end

   assign ss_rise  = sw.btn_start_stop & ~ss_q;
   assign clr_rise = sw.btn_clear      & ~clr_q;
   assign lap_rise = sw.btn_lap        & ~lap_q;

   assign count_en  = sw.tick_10ms & (state == ST_RUN);
   assign at_max    = (count == MAX_TIME);
   assign hold_stop = count_en & at_max & ~WRAP_EN;
   assign clr_count = clr_rise & (state != ST_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         running_r    <= 1'b0;
         lap_active_r <= 1'b0;
         snapshot     <= '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_STOP: begin
               if (clr_rise) begin
                  state        <= ST_IDLE;
                  running_r    <= 1'b0;
                  lap_active_r <= 1'b0;
               end else if (ss_rise) begin
                  state     <= ST_RUN;
                  running_r <= 1'b1;
               end
            end
            ST_RUN: begin
               // Lap snapshot takes the pre-tick count, even when stopping on the same edge.
               if (lap_rise) begin
                  if (lap_active_r) begin
                     lap_active_r <= 1'b0;
                  end else begin
                     snapshot     <= count;
                     lap_active_r <= 1'b1;
                  end
               end
               if (ss_rise || hold_stop) begin
                  state     <= ST_STOP;
                  running_r <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   // With wrap enabled the top carry is exactly the tick-at-maximum event.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= WRAP_EN ? carry[DIG_MIN_T] : (count_en & at_max);
      end
   end

   stopwatch_bcd_counter_bcd_digit #(.LIMIT(LIM_ONES)) u_cs_o (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (count_en & ~hold_stop),
      .q     (count[DIG_CS_O*DIGIT_W +: DIGIT_W]),
      .carry (carry[DIG_CS_O])
   );

   stopwatch_bcd_counter_bcd_digit #(.LIMIT(LIM_ONES)) u_cs_t (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (carry[DIG_CS_O]),
      .q     (count[DIG_CS_T*DIGIT_W +: DIGIT_W]),
      .carry (carry[DIG_CS_T])
   );

   stopwatch_bcd_counter_bcd_digit #(.LIMIT(LIM_ONES)) u_sec_o (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (carry[DIG_CS_T]),
      .q     (count[DIG_SEC_O*DIGIT_W +: DIGIT_W]),
      .carry (carry[DIG_SEC_O])
   );

   stopwatch_bcd_counter_bcd_digit #(.LIMIT(LIM_TENS)) u_sec_t (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (carry[DIG_SEC_O]),
      .q     (count[DIG_SEC_T*DIGIT_W +: DIGIT_W]),
      .carry (carry[DIG_SEC_T])
   );

   stopwatch_bcd_counter_bcd_digit #(.LIMIT(LIM_ONES)) u_min_o (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (carry[DIG_SEC_T]),
      .q     (count[DIG_MIN_O*DIGIT_W +: DIGIT_W]),
      .carry (carry[DIG_MIN_O])
   );

   stopwatch_bcd_counter_bcd_digit #(.LIMIT(LIM_TENS)) u_min_t (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (carry[DIG_MIN_O]),
      .q     (count[DIG_MIN_T*DIGIT_W +: DIGIT_W]),
      .carry (carry[DIG_MIN_T])
   );

   assign sw.digits     = lap_active_r ? snapshot : count;
   assign sw.running    = running_r;
   assign sw.lap_active = lap_active_r;
   assign sw.overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench: a centisecond-integer model predicts both wrap variants every cycle.
module tb_stopwatch_bcd_counter;

   localparam int MAXC   = 359999;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;

   typedef struct {
      logic [23:0] d;
      logic        run;
      logic        lap;
      logic        ovf;
   } exp_t;

   logic clk;
   logic reset;

   stopwatch_bcd_counter_if bus_w ();
   stopwatch_bcd_counter_if bus_h ();

   stopwatch_bcd_counter #(.WRAP_EN(1'b1)) dut_w (.clk(clk), .reset(reset), .sw(bus_w));
   stopwatch_bcd_counter #(.WRAP_EN(1'b0)) dut_h (.clk(clk), .reset(reset), .sw(bus_h));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb_w[$];
   exp_t sb_h[$];
   int   checks   = 0;
   int   failures = 0;

   int   m_state[2];
   int   m_cnt[2];
   int   m_snap[2];
   logic m_lap[2];
   logic m_wrap[2];
   logic p_ss, p_clr, p_lap;

   function automatic logic [23:0] to_bcd(input int c);
      int m, s, cs;
      m  = c / 6000;
      s  = (c / 100) % 60;
      cs = c % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   task automatic model_one(input int i, input logic t, ss, cl, lp, rs);
      logic rss, rcl, rlp, stop_req, ovf;
      int   old;
      exp_t e;
      rss = ss & ~p_ss;
      rcl = cl & ~p_clr;
      rlp = lp & ~p_lap;
      ovf = 1'b0;
      stop_req = 1'b0;
      old = m_cnt[i];
      if (rs) begin
         m_state[i] = M_IDLE; m_cnt[i] = 0; m_snap[i] = 0; m_lap[i] = 1'b0;
      end else begin
         if (t && m_state[i] == M_RUN) begin
            if (old == MAXC) begin
               ovf = 1'b1;
               if (m_wrap[i]) m_cnt[i] = 0;
               else stop_req = 1'b1;
            end else begin
               m_cnt[i] = old + 1;
            end
         end
         if (m_state[i] == M_RUN) begin
            if (rlp) begin
               if (m_lap[i]) m_lap[i] = 1'b0;
               else begin m_snap[i] = old; m_lap[i] = 1'b1; end
            end
            if (rss || stop_req) m_state[i] = M_STOP;
         end else if (rcl) begin
            m_state[i] = M_IDLE; m_cnt[i] = 0; m_lap[i] = 1'b0;
         end else if (rss) begin
            m_state[i] = M_RUN;
         end
      end
      e.d   = to_bcd(m_lap[i] ? m_snap[i] : m_cnt[i]);
      e.run = (m_state[i] == M_RUN);
      e.lap = m_lap[i];
      e.ovf = ovf;
      if (i == 0) sb_w.push_back(e);
      else        sb_h.push_back(e);
   endtask

   // Drive one cycle's inputs (sampled at the next posedge) and queue the expected result.
   task automatic drive_step(input logic t, ss, cl, lp, rs);
      reset = rs;
      bus_w.tick_10ms = t; bus_w.btn_start_stop = ss; bus_w.btn_clear = cl; bus_w.btn_lap = lp;
      bus_h.tick_10ms = t; bus_h.btn_start_stop = ss; bus_h.btn_clear = cl; bus_h.btn_lap = lp;
      model_one(0, t, ss, cl, lp, rs);
      model_one(1, t, ss, cl, lp, rs);
      p_ss = ss; p_clr = cl; p_lap = lp;
   endtask

   task automatic cycle(input logic t, ss, cl, lp, rs);
      @(negedge clk);
      drive_step(t, ss, cl, lp, rs);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input logic ss, cl, lp);
      cycle(1'b0, ss, cl, lp, 1'b0);
      idle();
   endtask

   task automatic ticks(input int n, input int max_gap);
      for (int k = 0; k < n; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         repeat ($urandom_range(0, max_gap)) idle();
      end
   endtask

   task automatic check_disp(input string name, input logic [23:0] act_d, exp_d,
                             input logic act_run, exp_run);
      checks++;
      if (act_d !== exp_d || act_run !== exp_run) begin
         failures++;
         $display("FAIL %s: digits=%h running=%b, expected digits=%h running=%b",
                  name, act_d, act_run, exp_d, exp_run);
      end
   endtask

   task automatic check_bit(input string name, input logic act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic sb_cmp(input string name, input exp_t e, input logic [23:0] d,
                         input logic r, l, o);
      checks++;
      if (d !== e.d || r !== e.run || l !== e.lap || o !== e.ovf) begin
         failures++;
         $display("FAIL %s t=%0t: digits=%h run=%b lap=%b ovf=%b, expected digits=%h run=%b lap=%b ovf=%b",
                  name, $time, d, r, l, o, e.d, e.run, e.lap, e.ovf);
      end
   endtask

   // Monitor: pops one prediction per DUT after every active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_w.size() > 0)
            sb_cmp("sb_wrap", sb_w.pop_front(), bus_w.digits, bus_w.running, bus_w.lap_active, bus_w.overflow);
         if (sb_h.size() > 0)
            sb_cmp("sb_hold", sb_h.pop_front(), bus_h.digits, bus_h.running, bus_h.lap_active, bus_h.overflow);
      end
   end

   initial begin
      logic ss_l, cl_l, lp_l;
      m_wrap[0] = 1'b1;
      m_wrap[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_state[i] = M_IDLE; m_cnt[i] = 0; m_snap[i] = 0; m_lap[i] = 1'b0;
      end
      p_ss = 1'b0; p_clr = 1'b0; p_lap = 1'b0;
      reset = 1'b1;
      bus_w.tick_10ms = 1'b0; bus_w.btn_start_stop = 1'b0; bus_w.btn_clear = 1'b0; bus_w.btn_lap = 1'b0;
      bus_h.tick_10ms = 1'b0; bus_h.btn_start_stop = 1'b0; bus_h.btn_clear = 1'b0; bus_h.btn_lap = 1'b0;
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      check_disp("reset_state", bus_w.digits, 24'h000000, bus_w.running, 1'b0);
      check_bit("reset_overflow", bus_w.overflow, 1'b0);

      // Ticks without any button press
      for (int k = 0; k < 100; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         repeat (9) idle();
      end
      check_disp("idle_ticks", bus_w.digits, 24'h000000, bus_w.running, 1'b0);

      // Start, 150 ticks, stop
      press(1'b1, 1'b0, 1'b0);
      ticks(150, 3);
      press(1'b1, 1'b0, 1'b0);
      check_disp("stop_150", bus_w.digits, 24'h000150, bus_w.running, 1'b0);
      ticks(20, 1);
      check_disp("stopped_hold", bus_w.digits, 24'h000150, bus_w.running, 1'b0);

      // One minute, then lap freeze
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      ticks(6000, 0);
      idle();
      check_disp("one_minute", bus_w.digits, 24'h010000, bus_w.running, 1'b1);
      press(1'b0, 1'b0, 1'b1);
      ticks(250, 0);
      idle();
      check_disp("lap_frozen", bus_w.digits, 24'h010000, bus_w.running, 1'b1);
      check_bit("lap_active_on", bus_w.lap_active, 1'b1);
      press(1'b0, 1'b0, 1'b1);
      check_disp("lap_released", bus_w.digits, 24'h010250, bus_w.running, 1'b1);

      // Preload 59:59.99 in both counters, then one tick
      @(negedge clk);
      force dut_w.u_min_t.q = 4'd5; force dut_w.u_min_o.q = 4'd9;
      force dut_w.u_sec_t.q = 4'd5; force dut_w.u_sec_o.q = 4'd9;
      force dut_w.u_cs_t.q  = 4'd9; force dut_w.u_cs_o.q  = 4'd9;
      force dut_h.u_min_t.q = 4'd5; force dut_h.u_min_o.q = 4'd9;
      force dut_h.u_sec_t.q = 4'd5; force dut_h.u_sec_o.q = 4'd9;
      force dut_h.u_cs_t.q  = 4'd9; force dut_h.u_cs_o.q  = 4'd9;
      m_cnt[0] = MAXC;
      m_cnt[1] = MAXC;
      drive_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      release dut_w.u_min_t.q; release dut_w.u_min_o.q;
      release dut_w.u_sec_t.q; release dut_w.u_sec_o.q;
      release dut_w.u_cs_t.q;  release dut_w.u_cs_o.q;
      release dut_h.u_min_t.q; release dut_h.u_min_o.q;
      release dut_h.u_sec_t.q; release dut_h.u_sec_o.q;
      release dut_h.u_cs_t.q;  release dut_h.u_cs_o.q;
      drive_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_disp("preload_max", bus_w.digits, 24'h595999, bus_w.running, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      check_disp("wrap_digits", bus_w.digits, 24'h000000, bus_w.running, 1'b1);
      check_bit("wrap_overflow", bus_w.overflow, 1'b1);
      check_disp("hold_digits", bus_h.digits, 24'h595999, bus_h.running, 1'b0);
      check_bit("hold_overflow", bus_h.overflow, 1'b1);
      idle();
      check_bit("overflow_one_clk", bus_w.overflow, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      check_disp("hold_restart", bus_h.digits, 24'h595999, bus_h.running, 1'b0);
      check_bit("hold_restart_ovf", bus_h.overflow, 1'b1);

      // Clear ignored while running; clear beats start when stopped
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      ticks(37, 2);
      press(1'b0, 1'b1, 1'b0);
      check_disp("clear_in_run", bus_w.digits, 24'h000037, bus_w.running, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      check_disp("stop_37", bus_w.digits, 24'h000037, bus_w.running, 1'b0);
      press(1'b1, 1'b1, 1'b0);
      check_disp("clear_beats_start", bus_w.digits, 24'h000000, bus_w.running, 1'b0);

      // Stop edge with a coincident tick at 00:00.09
      press(1'b1, 1'b0, 1'b0);
      ticks(9, 1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      check_disp("stop_with_tick", bus_w.digits, 24'h000010, bus_w.running, 1'b0);
      ticks(5, 1);
      check_disp("stop_tick_hold", bus_w.digits, 24'h000010, bus_w.running, 1'b0);

      // Reset mid-lap with a coincident tick
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      ticks(3, 1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      check_disp("reset_mid_run", bus_w.digits, 24'h000000, bus_w.running, 1'b0);
      check_bit("reset_mid_lap", bus_w.lap_active, 1'b0);

      // Start button held through reset
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_disp("held_through_reset", bus_w.digits, 24'h000000, bus_w.running, 1'b0);
      idle();

      // Random button/tick traffic
      ss_l = 1'b0; cl_l = 1'b0; lp_l = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 19) == 0) ss_l = ~ss_l;
         if ($urandom_range(0, 24) == 0) cl_l = ~cl_l;
         if ($urandom_range(0, 14) == 0) lp_l = ~lp_l;
         cycle($urandom_range(0, 2) == 0, ss_l, cl_l, lp_l, $urandom_range(0, 799) == 0);
      end
      repeat (2) idle();

      @(posedge clk);
      #2;
      checks++;
      if (sb_w.size() != 0 || sb_h.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d/%0d predictions left, expected 0/0", sb_w.size(), sb_h.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
